// File: rtl/game_round_ctrl_pkg.sv
// Shared types and constants for the guessing-game round sequencer.
// State encoding, display select codes and the all-correct verdict.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        SHOW  = 3'd4,
        WIN   = 3'd5,
        LOSE  = 3'd6
    } state_t;

    localparam logic [1:0] SEL_IDLE = 2'b00;
    localparam logic [1:0] SEL_PLAY = 2'b01;
    localparam logic [1:0] SEL_WIN  = 2'b10;
    localparam logic [1:0] SEL_LOSE = 2'b11;

    localparam logic [5:0] WIN_CODE = 6'b100000;

    function automatic logic [1:0] sel_of(state_t s);
        case (s)
            IDLE, ARM, WAIT: return SEL_IDLE;
            CHECK, SHOW:     return SEL_PLAY;
            WIN:             return SEL_WIN;
            default:         return SEL_LOSE;
        endcase
    endfunction

    function automatic logic [7:0] time_limit(logic [1:0] lvl, int base, int step);
        return 8'(base - int'(lvl) * step);
    endfunction

endpackage

// File: rtl/game_round_ctrl_if.sv
// Bundle between the round sequencer and the checker/timer/display blocks.
// master is the sequencer side, slave is the surrounding datapath.
interface game_round_ctrl_if #(
    parameter int RES_W = 6
);
    logic             btn;
    logic [RES_W-1:0] check_result;
    logic             check_valid;
    logic             check_start;
    logic             timer_load;
    logic [7:0]       timer_value;
    logic             timer_en;
    logic             timer_finish;
    logic [1:0]       led_sel;
    logic [1:0]       seg_sel;
    logic [3:0]       tries;
    logic [7:0]       score;
    logic [1:0]       level;

    modport master (
        input  btn, check_result, check_valid, timer_finish,
        output check_start, timer_load, timer_value, timer_en,
        output led_sel, seg_sel, tries, score, level
    );

    modport slave (
        output btn, check_result, check_valid, timer_finish,
        input  check_start, timer_load, timer_value, timer_en,
        input  led_sel, seg_sel, tries, score, level
    );
endinterface

// File: rtl/game_round_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int          W   = 4,
    parameter int unsigned MAX = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && q != W'(MAX))
            q <= q + 1'b1;
    end

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer: arms the timer, starts the checker, tracks tries/score/level.
// Every output is registered from next_state so it is valid on state entry.
module game_round_ctrl
    import game_pkg::*;
#(
    parameter int             RES_W     = 6,
    parameter logic [RES_W-1:0] WIN_CODE = game_pkg::WIN_CODE,
    parameter int             MAX_TRIES = 8,
    parameter int             TIME_BASE = 30,
    parameter int             TIME_STEP = 5,
    parameter int             LEVELS    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    game_round_ctrl_if.master     bus
);

    state_t state, next_state;
    logic   enter_check, enter_win, enter_lose, enter_arm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:  if (bus.btn) next_state = ARM;
            ARM:   next_state = WAIT;
            WAIT: begin
                if (bus.timer_finish)
                    next_state = LOSE;
                else if (bus.btn)
                    next_state = CHECK;
            end
            CHECK: begin
                // a verdict arriving with expiry still counts
                if (bus.check_valid) begin
                    if (bus.check_result == WIN_CODE)
                        next_state = WIN;
                    else if (bus.tries == 4'(MAX_TRIES))
                        next_state = LOSE;
                    else
                        next_state = SHOW;
                end else if (bus.timer_finish) begin
                    next_state = LOSE;
                end
            end
            SHOW: begin
                if (bus.timer_finish)
                    next_state = LOSE;
                else if (bus.btn)
                    next_state = WAIT;
            end
            WIN:   if (bus.btn) next_state = ARM;
            LOSE:  if (bus.btn) next_state = ARM;
            default: next_state = IDLE;
        endcase
    end

    assign enter_arm   = (next_state == ARM);
    assign enter_check = (next_state == CHECK) && (state != CHECK);
    assign enter_win   = (next_state == WIN)   && (state != WIN);
    assign enter_lose  = (next_state == LOSE)  && (state != LOSE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.check_start <= 1'b0;
            bus.timer_load  <= 1'b0;
            bus.timer_value <= '0;
            bus.timer_en    <= 1'b0;
            bus.led_sel     <= SEL_IDLE;
            bus.seg_sel     <= SEL_IDLE;
        end else begin
            bus.check_start <= enter_check;
            bus.timer_load  <= enter_arm;
            if (enter_arm)
                bus.timer_value <= time_limit(bus.level, TIME_BASE, TIME_STEP);
            bus.timer_en    <= (next_state == WAIT) ||
                               (next_state == CHECK) ||
                               (next_state == SHOW);
            bus.led_sel     <= sel_of(next_state);
            bus.seg_sel     <= sel_of(next_state);
        end
    end

    sat_counter #(.W(4), .MAX(MAX_TRIES)) u_tries (
        .clk (clk),
        .rst (rst),
        .inc (enter_check),
        .clr (enter_arm),
        .q   (bus.tries)
    );

    sat_counter #(.W(8), .MAX(255)) u_score (
        .clk (clk),
        .rst (rst),
        .inc (enter_win),
        .clr (1'b0),
        .q   (bus.score)
    );

    sat_counter #(.W(2), .MAX(LEVELS - 1)) u_level (
        .clk (clk),
        .rst (rst),
        .inc (enter_win),
        .clr (enter_lose),
        .q   (bus.level)
    );

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl with hand-computed expectations.
module tb_game_round_ctrl;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    localparam logic [5:0] WIN  = 6'b100000;
    localparam logic [5:0] MISS = 6'b000001;

    game_round_ctrl_if #(.RES_W(6)) bus ();

    game_round_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        bus.btn = 1'b1;
        tick();
        bus.btn = 1'b0;
    endtask

    task automatic answer(input logic [5:0] res);
        bus.check_valid  = 1'b1;
        bus.check_result = res;
        tick();
        bus.check_valid  = 1'b0;
        bus.check_result = '0;
    endtask

    task automatic expire();
        bus.timer_finish = 1'b1;
        tick();
        bus.timer_finish = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.btn = 1'b0;
        bus.check_valid = 1'b0;
        bus.check_result = '0;
        bus.timer_finish = 1'b0;
        #12;
        chk("rst_load", bus.timer_load, 0);
        chk("rst_value", bus.timer_value, 0);
        chk("rst_en", bus.timer_en, 0);
        chk("rst_start", bus.check_start, 0);
        chk("rst_led", bus.led_sel, 0);
        chk("rst_seg", bus.seg_sel, 0);
        chk("rst_tries", bus.tries, 0);
        chk("rst_score", bus.score, 0);
        chk("rst_level", bus.level, 0);
        rst = 1'b0;
        tick();
        chk("idle_en", bus.timer_en, 0);

        // round 1: win at level 0
        press();
        chk("r1_arm_load", bus.timer_load, 1);
        chk("r1_arm_value", bus.timer_value, 30);
        chk("r1_arm_led", bus.led_sel, 0);
        tick();
        chk("r1_wait_load", bus.timer_load, 0);
        chk("r1_wait_en", bus.timer_en, 1);
        press();
        chk("r1_chk_start", bus.check_start, 1);
        chk("r1_chk_tries", bus.tries, 1);
        chk("r1_chk_led", bus.led_sel, 1);
        chk("r1_chk_seg", bus.seg_sel, 1);
        tick();
        chk("r1_chk_start2", bus.check_start, 0);
        answer(WIN);
        chk("r1_win_led", bus.led_sel, 2);
        chk("r1_win_seg", bus.seg_sel, 2);
        chk("r1_win_score", bus.score, 1);
        chk("r1_win_level", bus.level, 1);
        chk("r1_win_en", bus.timer_en, 0);

        // round 2: eight misses at level 1
        press();
        chk("r2_arm_value", bus.timer_value, 25);
        chk("r2_arm_tries", bus.tries, 0);
        tick();
        for (int i = 1; i <= 8; i++) begin
            press();
            chk("r2_start", bus.check_start, 1);
            chk("r2_tries", bus.tries, 32'(i));
            answer(MISS);
            if (i < 8) begin
                chk("r2_show_led", bus.led_sel, 1);
                chk("r2_show_en", bus.timer_en, 1);
                press();
                chk("r2_back_led", bus.led_sel, 0);
            end
        end
        chk("r2_lose_led", bus.led_sel, 3);
        chk("r2_lose_tries", bus.tries, 8);
        chk("r2_lose_level", bus.level, 0);
        chk("r2_lose_score", bus.score, 1);
        chk("r2_lose_en", bus.timer_en, 0);

        // expiry in WAIT
        press();
        chk("tw_arm_value", bus.timer_value, 30);
        tick();
        expire();
        chk("tw_led", bus.led_sel, 3);
        chk("tw_en", bus.timer_en, 0);

        // expiry in SHOW
        press();
        tick();
        press();
        answer(MISS);
        chk("ts_show_led", bus.led_sel, 1);
        expire();
        chk("ts_led", bus.led_sel, 3);
        chk("ts_en", bus.timer_en, 0);

        // expiry in CHECK before a verdict
        press();
        tick();
        press();
        expire();
        chk("tc_led", bus.led_sel, 3);
        chk("tc_en", bus.timer_en, 0);

        // btn and expiry together in WAIT
        press();
        tick();
        bus.btn = 1'b1;
        bus.timer_finish = 1'b1;
        tick();
        bus.btn = 1'b0;
        bus.timer_finish = 1'b0;
        chk("tb_led", bus.led_sel, 3);
        chk("tb_start", bus.check_start, 0);

        // verdict beats expiry
        press();
        tick();
        press();
        bus.timer_finish = 1'b1;
        answer(WIN);
        bus.timer_finish = 1'b0;
        chk("vt_led", bus.led_sel, 2);
        chk("vt_score", bus.score, 2);
        chk("vt_level", bus.level, 1);

        // extra presses in CHECK, stray verdict in WAIT
        press();
        chk("xb_arm_value", bus.timer_value, 25);
        tick();
        press();
        chk("xb_tries1", bus.tries, 1);
        press();
        chk("xb_start", bus.check_start, 0);
        chk("xb_tries", bus.tries, 1);
        chk("xb_led", bus.led_sel, 1);
        answer(MISS);
        press();
        chk("xb_wait_led", bus.led_sel, 0);
        answer(WIN);
        chk("xv_led", bus.led_sel, 0);
        chk("xv_en", bus.timer_en, 1);
        chk("xv_score", bus.score, 2);

        // async reset mid-CHECK
        press();
        chk("ar_start_pre", bus.check_start, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_start", bus.check_start, 0);
        chk("ar_en", bus.timer_en, 0);
        chk("ar_led", bus.led_sel, 0);
        chk("ar_tries", bus.tries, 0);
        chk("ar_score", bus.score, 0);
        chk("ar_level", bus.level, 0);
        #3;
        rst = 1'b0;
        tick();
        chk("ar_idle_en", bus.timer_en, 0);
        press();
        chk("ar_arm_load", bus.timer_load, 1);
        chk("ar_arm_value", bus.timer_value, 30);
        tick();

        // score saturation over many wins
        press();
        answer(WIN);
        for (int i = 1; i < 255; i++) begin
            press();
            tick();
            press();
            answer(WIN);
        end
        chk("sat_score", bus.score, 255);
        chk("sat_level", bus.level, 3);
        press();
        chk("sat_arm_value", bus.timer_value, 15);
        tick();
        press();
        answer(WIN);
        chk("sat_score2", bus.score, 255);
        chk("sat_level2", bus.level, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
Round-level sequencer for the guessing game. It arms the countdown timer with a level-dependent limit and starts the answer checker through a start/valid handshake. It counts attempts, keeps score and level, and drives the LED and segment display selects. It sits above the checker, timer and display muxes and owns every enable and start pulse into them.

Parameters:
RES_W, 6, width of check_result
WIN_CODE, 6'b100000, check_result value meaning all digits correct
MAX_TRIES, 8, attempts per round before loss (1..15)
TIME_BASE, 30, timer limit in seconds at level 0
TIME_STEP, 5, seconds removed per level
LEVELS, 4, number of levels (level saturates at LEVELS-1)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
btn  in  1  debounced single-cycle press pulse
check_result  in  RES_W  checker verdict, sampled only when check_valid=1
check_valid  in  1  checker done pulse
check_start  out  1  one-cycle checker start pulse
timer_load  out  1  one-cycle load of timer_value into timer
timer_value  out  8  countdown limit in seconds
timer_en  out  1  timer count enable
timer_finish  in  1  timer expired (level)
led_sel  out  2  LED pattern select
seg_sel  out  2  7-seg source select
tries  out  4  attempts used this round
score  out  8  rounds won, saturating
level  out  2  current level

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; tries=0, score=0, level=0.
- All outputs are registered and decoded from next_state, so each value is valid in the first cycle of its state.
- States and transitions:
  - IDLE: btn -> ARM.
  - ARM: exactly one cycle. timer_load=1, timer_value=TIME_BASE-level*TIME_STEP (8-bit unsigned), tries<=0. Then WAIT.
  - WAIT: timer_en=1. timer_finish -> LOSE; else btn -> CHECK.
  - CHECK: timer_en=1. check_start=1 only in the first CHECK cycle, and tries increments by 1 in that same cycle. Stay until check_valid.
    - check_valid with check_result==WIN_CODE -> WIN.
    - check_valid with other result and tries==MAX_TRIES -> LOSE.
    - check_valid otherwise -> SHOW.
    - timer_finish with no check_valid -> LOSE.
  - SHOW: timer_en=1. timer_finish -> LOSE; else btn -> WAIT.
  - WIN: timer_en=0. On entry score+1 (saturates at 255) and level+1 (saturates at LEVELS-1). btn -> ARM.
  - LOSE: timer_en=0. On entry level<=0; score is held. btn -> ARM.
- Priorities:
  - check_valid beats timer_finish in the same cycle (answer counted).
  - timer_finish beats btn in WAIT and SHOW.
- btn in ARM, or in CHECK before check_valid, is ignored and not queued.
- check_valid outside CHECK is ignored.
- led_sel/seg_sel by state: IDLE/ARM/WAIT 00; CHECK/SHOW 01; WIN 10; LOSE 11.
- tries never exceeds MAX_TRIES and does not wrap.
- Reset mid-round aborts immediately. No pulse is emitted in the reset cycle.

Decomposition:
- Shared package game_pkg: state encoding (3-bit: IDLE, ARM, WAIT, CHECK, SHOW, WIN, LOSE), led/seg select codes, WIN_CODE.
- One natural sub-module: sat_counter (parameterised width/max, inc and clr inputs), instanced for tries, score and level.

Test Plan:
- Reset, btn, then btn at level 0 -> ARM pulses timer_load with timer_value=30; check_start pulses once; check_valid with 6'b100000 -> WIN, score=1, level=1, led_sel=seg_sel=10.
- Next round (btn from WIN) -> timer_value=25; 8 wrong answers with btn to leave SHOW each time -> eighth check_valid gives LOSE, tries=8, level=0, score still 1.
- timer_finish asserted in WAIT, SHOW, and CHECK before valid -> LOSE next cycle with timer_en=0; btn and timer_finish together in WAIT -> LOSE.
- check_valid (WIN_CODE) and timer_finish in the same CHECK cycle -> WIN.
- Extra btn presses during CHECK -> no second check_start and tries unchanged; check_valid injected in WAIT -> no state change.
- rst asserted mid-CHECK, asynchronous to clk -> all outputs 0 immediately, state IDLE; 255 wins -> score stays 255.
